// File: rtl/reduce_pkg.sv
// Reduction flit layout shared by the ingress arbiter and the reduce unit.
// Offsets are relative to the payload width; the payload occupies bits [PayloadWidth-1:0].
package reduce_pkg;
  localparam int ALG_OFS   = 0;
  localparam int ALG_W     = 2;
  localparam int OP_OFS    = 2;
  localparam int OP_W      = 4;
  localparam int TAG_OFS   = 6;
  localparam int TAG_W     = 8;
  localparam int CTX_OFS   = 14;
  localparam int CTX_W     = 4;
  localparam int RANK_OFS  = 18;
  localparam int RANK_W    = 8;
  localparam int SRC_OFS   = 26;
  localparam int SRC_W     = 8;
  localparam int DST_OFS   = 34;
  localparam int DST_W     = 8;
  localparam int VALID_OFS = 49;
  localparam int HDR_W     = 50;

  // Reduction flits carry 2'b11 in op[3:2].
  localparam logic [1:0] OP_REDUCE = 2'b11;

  typedef enum logic [1:0] {
    ALG_SUM = 2'b00,
    ALG_MAX = 2'b01,
    ALG_MIN = 2'b10,
    ALG_BOR = 2'b11
  } alg_op_e;

  // Full flit width for a given payload width; the children field sits right above it.
  function automatic int flit_w(input int payload_w);
    return payload_w + HDR_W;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the pointer
// moves past the winner only when the grant is actually taken.
module rr_arbiter #(
  parameter  int NUM_PORTS = 4,
  localparam int PTRW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PTRW-1:0]      grant_idx
);
  logic [PTRW-1:0] ptr;
  logic [PTRW-1:0] idx;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = PTRW'((int'(ptr) + i) % NUM_PORTS);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (advance)
      ptr <= (grant_idx == PTRW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
  end
endmodule

// File: rtl/reduce_ingress_arbiter.sv
// Feeds reduction flits from NUM_PORTS input queues into the shared reduce unit,
// spacing same-slot issues by the adder latency and prepending the children count.
module reduce_ingress_arbiter
  import reduce_pkg::*;
#(
  parameter int NUM_PORTS          = 4,
  parameter int lg_numprocs        = 3,
  parameter int PayloadWidth       = 32,
  parameter int ReductionTableSize = 2,
  parameter int AdderLatency       = 4,
  localparam int IW = (ReductionTableSize > 1) ? $clog2(ReductionTableSize) : 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_PORTS-1:0]                        req_valid,
  input  logic [NUM_PORTS*(PayloadWidth+HDR_W)-1:0]   req_flit,
  output logic [NUM_PORTS-1:0]                        req_ready,
  input  logic                                        cfg_we,
  input  logic [IW-1:0]                               cfg_slot,
  input  logic [lg_numprocs-1:0]                      cfg_children,
  output logic                                        out_valid,
  output logic [PayloadWidth+HDR_W+lg_numprocs-1:0]   out_flit,
  input  logic                                        out_ready,
  output logic [15:0]                                 issued_count,
  output logic [15:0]                                 drop_count
);
  localparam int FW   = PayloadWidth + HDR_W;
  localparam int CW   = $clog2(AdderLatency + 1);
  localparam int PTRW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0][FW-1:0] flits;
  logic [IW-1:0]                slot_of [NUM_PORTS];
  logic [NUM_PORTS-1:0]         eligible;
  logic [CW-1:0]                cool [ReductionTableSize];
  logic [lg_numprocs-1:0]       child_tbl [ReductionTableSize];

  logic [NUM_PORTS-1:0] grant;
  logic [PTRW-1:0]      gidx;
  logic                 can_take;
  logic                 grant_any;
  logic [FW-1:0]        gflit;
  logic [IW-1:0]        gslot;

  assign flits = req_flit;

  // A flit with its valid bit clear is always eligible: it is only drained, never issued.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign slot_of[p]  = flits[p][PayloadWidth+TAG_OFS +: IW];
    assign eligible[p] = req_valid[p] & (~flits[p][FW-1] | (cool[slot_of[p]] == '0));
  end

  assign can_take = ~rst & (~out_valid | out_ready);

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (eligible & {NUM_PORTS{can_take}}),
    .advance   (grant_any),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign grant_any = |grant;
  assign req_ready = grant;
  assign gflit     = flits[gidx];
  assign gslot     = slot_of[gidx];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_flit     <= '0;
      issued_count <= '0;
      drop_count   <= '0;
      for (int s = 0; s < ReductionTableSize; s++) begin
        cool[s]      <= '0;
        child_tbl[s] <= '0;
      end
    end else begin
      for (int s = 0; s < ReductionTableSize; s++)
        if (cool[s] != '0) cool[s] <= cool[s] - 1'b1;

      // Table write lands at this edge, so a same-cycle issue still reads the old entry.
      if (cfg_we) child_tbl[cfg_slot] <= cfg_children;

      if (out_valid && out_ready) out_valid <= 1'b0;

      if (grant_any) begin
        if (gflit[FW-1]) begin
          out_valid    <= 1'b1;
          out_flit     <= {child_tbl[gslot], gflit};
          cool[gslot]  <= CW'(AdderLatency);
          issued_count <= issued_count + 16'd1;
        end else begin
          drop_count   <= drop_count + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_reduce_ingress_arbiter.sv
// Directed bench for reduce_ingress_arbiter: stimulus pushes expected {children, flit}
// words into a queue; a negedge monitor pops one per accepted output.
module tb_reduce_ingress_arbiter;
  localparam int N  = 4;
  localparam int LP = 3;
  localparam int PW = 32;
  localparam int FW = PW + 50;
  localparam int OW = FW + LP;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0][FW-1:0] pf;
  logic [N-1:0]         req_ready;
  logic                 cfg_we;
  logic                 cfg_slot;
  logic [LP-1:0]        cfg_children;
  logic                 out_valid;
  logic [OW-1:0]        out_flit;
  logic                 out_ready;
  logic [15:0]          issued_count;
  logic [15:0]          drop_count;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] expq[$];
  logic [OW-1:0] held;
  logic [N-1:0]  exp_rdy [7];

  always #5 clk = ~clk;

  reduce_ingress_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_flit     (pf),
    .req_ready    (req_ready),
    .cfg_we       (cfg_we),
    .cfg_slot     (cfg_slot),
    .cfg_children (cfg_children),
    .out_valid    (out_valid),
    .out_flit     (out_flit),
    .out_ready    (out_ready),
    .issued_count (issued_count),
    .drop_count   (drop_count)
  );

  function automatic logic [FW-1:0] mk(input logic v, input logic [7:0] tag, input logic [31:0] pay);
    logic [FW-1:0] f;
    f               = '0;
    f[FW-1]         = v;
    f[PW+13:PW+6]   = tag;
    f[PW+5:PW+4]    = 2'b11;
    f[PW-1:0]       = pay;
    return f;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: an output is accepted at the edge following a negedge where valid & ready.
  initial begin
    logic [OW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected actual=%0h required=none", out_flit);
        end else begin
          e = expq.pop_front();
          if (out_flit !== e) begin
            errors++;
            $display("FAIL out_flit actual=%0h required=%0h", out_flit, e);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; pf = '0;
    cfg_we = 1'b0; cfg_slot = 1'b0; cfg_children = '0; out_ready = 1'b1;
    repeat (3) step();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_issued", issued_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;

    // Single issue with programmed children, then same-slot spacing.
    cfg_we = 1'b1; cfg_slot = 1'b1; cfg_children = 3'd2;
    step();
    cfg_we = 1'b0;
    pf[0] = mk(1'b1, 8'h01, 32'h0000_00A0); req_valid = 4'b0001;
    #1 chk("p1_grant0", req_ready, 4'b0001);
    expq.push_back({3'd2, pf[0]});
    step();
    req_valid = '0;
    #1;
    chk("p1_out_valid", out_valid, 1);
    chk("p1_issued", issued_count, 1);
    pf[1] = mk(1'b1, 8'h01, 32'h0000_00B1); req_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) #1;
      chk("p1_cool_block", req_ready, 4'b0000);
      step();
    end
    #1 chk("p1_cool_release", req_ready, 4'b0010);
    expq.push_back({3'd2, pf[1]});
    step();
    req_valid = '0;

    // Four ports, tags 0,1,0,1; pointer starts at 2.
    repeat (6) step();
    for (int p = 0; p < N; p++) pf[p] = mk(1'b1, 8'(p % 2), 32'hC0 + 32'(p));
    req_valid = 4'b1111;
    exp_rdy = '{4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
    for (int k = 0; k < 7; k++) begin
      #1 chk("p2_grant", req_ready, exp_rdy[k]);
      for (int p = 0; p < N; p++)
        if (exp_rdy[k][p]) expq.push_back({(p % 2 == 1) ? 3'd2 : 3'd0, pf[p]});
      step();
      req_valid = req_valid & ~exp_rdy[k];
    end

    // Ports 0 and 3 continuously valid on different slots.
    repeat (5) step();
    pf[0] = mk(1'b1, 8'h00, 32'hD0); pf[3] = mk(1'b1, 8'h01, 32'hD3);
    req_valid = 4'b1001;
    exp_rdy = '{4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001};
    for (int k = 0; k < 7; k++) begin
      #1 chk("p3_alternate", req_ready, exp_rdy[k]);
      for (int p = 0; p < N; p++)
        if (exp_rdy[k][p]) expq.push_back({(p == 3) ? 3'd2 : 3'd0, pf[p]});
      step();
      for (int p = 0; p < N; p++)
        if (exp_rdy[k][p]) pf[p][PW-1:0] = pf[p][PW-1:0] + 32'h100;
    end
    req_valid = '0;

    // Backpressure: output held for 6 cycles, then released.
    repeat (6) step();
    pf[1] = mk(1'b1, 8'h01, 32'hE1); req_valid = 4'b0010;
    #1 chk("p4_grant", req_ready, 4'b0010);
    held = {3'd2, pf[1]};
    expq.push_back(held);
    step();
    out_ready = 1'b0;
    pf[2] = mk(1'b1, 8'h00, 32'hE2); req_valid = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("p4_stall_ready", req_ready, 4'b0000);
      chk("p4_stall_valid", out_valid, 1);
      chk("p4_stall_flit", out_flit, held);
      step();
    end
    out_ready = 1'b1;
    #1 chk("p4_release", req_ready, 4'b0100);
    expq.push_back({3'd0, pf[2]});
    step();
    req_valid = '0;

    // Invalid flit is drained and counted, never forwarded.
    pf[2] = mk(1'b0, 8'h00, 32'hF2); req_valid = 4'b0100;
    #1 chk("p5_drop_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    #1;
    chk("p5_drop_count", drop_count, 1);
    chk("p5_out_valid", out_valid, 0);
    chk("p5_issued", issued_count, 12);

    // Config write in the same cycle as an issue to that slot.
    repeat (5) step();
    pf[0] = mk(1'b1, 8'h00, 32'h60); req_valid = 4'b0001;
    cfg_we = 1'b1; cfg_slot = 1'b0; cfg_children = 3'd5;
    #1 chk("p6_grant_old", req_ready, 4'b0001);
    expq.push_back({3'd0, pf[0]});
    step();
    cfg_we = 1'b0;
    pf[1] = mk(1'b1, 8'h00, 32'h61); req_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      #1 chk("p6_cool_block", req_ready, 4'b0000);
      step();
    end
    #1 chk("p6_grant_new", req_ready, 4'b0010);
    expq.push_back({3'd5, pf[1]});
    step();
    req_valid = '0;

    // Reset with a flit stalled in the output register.
    pf[2] = mk(1'b1, 8'h01, 32'h72); req_valid = 4'b0100;
    #1 chk("p7_grant", req_ready, 4'b0100);
    held = {3'd2, pf[2]};
    step();
    out_ready = 1'b0; req_valid = '0;
    #1;
    chk("p7_hold_valid", out_valid, 1);
    chk("p7_hold_flit", out_flit, held);
    rst = 1'b1;
    pf[0] = mk(1'b1, 8'h01, 32'h80); req_valid = 4'b0001;
    step();
    #1;
    chk("p7_rst_ready", req_ready, 0);
    chk("p7_rst_valid", out_valid, 0);
    chk("p7_rst_flit", out_flit, 0);
    chk("p7_rst_issued", issued_count, 0);
    chk("p7_rst_drop", drop_count, 0);
    rst = 1'b0; out_ready = 1'b1;
    pf[1] = mk(1'b1, 8'h01, 32'h81); req_valid = 4'b0011;
    #1 chk("p7_ptr_reset", req_ready, 4'b0001);
    expq.push_back({3'd0, pf[0]});
    step();
    req_valid = '0;
    #1 chk("p7_issued", issued_count, 1);

    for (int i = 0; i < 20 && expq.size() != 0; i++) step();
    chk("queue_drained", 128'(expq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
